// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type and constants for mem_arbiter_2m
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hdeadbeef;
  localparam int          WAIT_CNT_W    = 16;

endpackage

// File: rtl/mem_arbiter_2m_rr_pick2.sv
// rtl/mem_arbiter_2m_rr_pick2.sv - combinational 2-way round-robin pick
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic win_o,
  output logic any_o
);

  assign any_o = req0_i | req1_i;
  // On a tie the master that was not granted last time wins.
  assign win_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/mem_arbiter_2m.sv
// rtl/mem_arbiter_2m.sv - two-master round-robin arbiter for a picorv32 native memory port
// Optional slave-wait timeout enabled by defining MEM_ARBITER_2M_TIMEOUT_EN.
module mem_arbiter_2m
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_ready,
  input  logic [31:0]       s_rdata,
  output logic              grant,
  output logic              timeout_err
);

  arb_state_e        state_q;
  logic              s_valid_q;
  logic              s_instr_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [31:0]       s_wdata_q;
  logic [3:0]        s_wstrb_q;
  logic              m0_ready_q;
  logic              m1_ready_q;
  logic [31:0]       m0_rdata_q;
  logic [31:0]       m1_rdata_q;
  logic              grant_q;
  logic              timeout_err_q;

  logic              win_d;
  logic              any_req;
  logic              timed_out;
  logic [31:0]       rsp_data;

  rr_pick2 u_pick (
    .req0_i (m0_valid),
    .req1_i (m1_valid),
    .last_i (grant_q),
    .win_o  (win_d),
    .any_o  (any_req)
  );

`ifdef MEM_ARBITER_2M_TIMEOUT_EN
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_CNT_W-1:0] wait_cnt_q;

  // Held at zero outside REQ so every new request starts a fresh count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt_q <= '0;
    end else if (state_q != REQ) begin
      wait_cnt_q <= '0;
    end else if (!s_ready) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timed_out = (state_q == REQ) && !s_ready && (wait_cnt_q == WAIT_LAST);
`else
  assign timed_out = 1'b0;
`endif

  // A real s_ready always beats a timeout on the same edge.
  assign rsp_data = !s_ready           ? TIMEOUT_RDATA :
                    (s_wstrb_q == 4'd0) ? s_rdata       : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      s_valid_q     <= 1'b0;
      s_instr_q     <= 1'b0;
      s_addr_q      <= '0;
      s_wdata_q     <= 32'd0;
      s_wstrb_q     <= 4'd0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      m0_rdata_q    <= 32'd0;
      m1_rdata_q    <= 32'd0;
      grant_q       <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            s_valid_q <= 1'b1;
            grant_q   <= win_d;
            s_instr_q <= win_d ? m1_instr : m0_instr;
            s_addr_q  <= win_d ? m1_addr  : m0_addr;
            s_wdata_q <= win_d ? m1_wdata : m0_wdata;
            s_wstrb_q <= win_d ? m1_wstrb : m0_wstrb;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (s_ready || timed_out) begin
            s_valid_q     <= 1'b0;
            timeout_err_q <= !s_ready;
            if (grant_q) begin
              m1_ready_q <= 1'b1;
              m1_rdata_q <= rsp_data;
            end else begin
              m0_ready_q <= 1'b1;
              m0_rdata_q <= rsp_data;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          m0_ready_q <= 1'b0;
          m1_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_valid     = s_valid_q;
  assign s_instr     = s_instr_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;

endmodule
